trav_stack_ctl: RTL

Consumes the per-node traversal decision produced by the kd-tree traversal math unit (only_low / only_high / lo-then-hi / hi-then-lo, plus t_min, t_max and t_mid) and turns it into the next node request for the ray. The request carries a node index and a t-interval. When both children are visited, the far child and its t-interval are pushed onto a per-ray short stack. Leaf-complete requests pop that stack to resume traversal, or report the ray done. It sits directly downstream of the traversal math pipeline and feeds the node-fetch stage.

---
 rtl/trav_stack_ctl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/trav_stack_ctl.sv
// Per-ray traversal stack controller. Turns kd-tree split decisions into next-node
// requests, stashing far children on a short per-ray stack for later resume.
module trav_stack_ctl #(
  parameter int NUM_RAYS = 8,
  parameter int DEPTH    = 8,
  parameter int NODE_W   = 16,
  localparam int RID_W   = $clog2(NUM_RAYS),
  localparam int DW      = $clog2(DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [RID_W-1:0]  dec_ray_id,
  input  logic [NODE_W-1:0] dec_lo_child,
  input  logic [NODE_W-1:0] dec_hi_child,
  input  logic [31:0]       dec_t_min,
  input  logic [31:0]       dec_t_max,
  input  logic [31:0]       dec_t_mid,
  input  logic              dec_only_low,
  input  logic              dec_only_high,
  input  logic              dec_lo_then_hi,
  input  logic              dec_hi_then_lo,
  input  logic              pop_valid,
  output logic              pop_ready,
  input  logic [RID_W-1:0]  pop_ray_id,
  output logic              nxt_valid,
  input  logic              nxt_ready,
  output logic [RID_W-1:0]  nxt_ray_id,
  output logic [NODE_W-1:0] nxt_node,
  output logic [31:0]       nxt_t_min,
  output logic [31:0]       nxt_t_max,
  output logic              nxt_done,
  output logic              ovf_err,
  output logic              flag_err
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [31:0] float_t;
  typedef struct packed {
    logic [NODE_W-1:0] node;
    float_t            t_min;
    float_t            t_max;
  } ent_t;

  logic [DW-1:0] cnt [NUM_RAYS];
  ent_t          stk [NUM_RAYS][DEPTH];

  logic          dec_fire, pop_fire, any_flag, push, full;
  ent_t          dec_out, push_ent, pop_ent;
  logic [DW-1:0] push_cnt, pop_cnt;

  assign dec_ready = ~nxt_valid | nxt_ready;
  assign pop_ready = dec_ready & ~dec_valid;
  assign dec_fire  = dec_valid & dec_ready;
  assign pop_fire  = pop_valid & pop_ready;
  assign any_flag  = dec_lo_then_hi | dec_hi_then_lo | dec_only_low | dec_only_high;

  assign push_cnt = cnt[dec_ray_id];
  assign full     = (push_cnt == DW'(DEPTH));
  assign pop_cnt  = cnt[pop_ray_id];
  // Garbage when pop_cnt == 0; that case emits a done token instead.
  assign pop_ent  = stk[pop_ray_id][IW'(pop_cnt - 1'b1)];

  // Near child goes out now, far child is deferred with the back half of the interval.
  always_comb begin
    dec_out  = '0;
    push_ent = '0;
    push     = 1'b0;
    if (dec_lo_then_hi) begin
      dec_out  = '{dec_lo_child, dec_t_min, dec_t_mid};
      push_ent = '{dec_hi_child, dec_t_mid, dec_t_max};
      push     = 1'b1;
    end else if (dec_hi_then_lo) begin
      dec_out  = '{dec_hi_child, dec_t_min, dec_t_mid};
      push_ent = '{dec_lo_child, dec_t_mid, dec_t_max};
      push     = 1'b1;
    end else if (dec_only_low) begin
      dec_out  = '{dec_lo_child, dec_t_min, dec_t_max};
    end else if (dec_only_high) begin
      dec_out  = '{dec_hi_child, dec_t_min, dec_t_max};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nxt_valid  <= 1'b0;
      nxt_done   <= 1'b0;
      nxt_ray_id <= '0;
      nxt_node   <= '0;
      nxt_t_min  <= '0;
      nxt_t_max  <= '0;
      ovf_err    <= 1'b0;
      flag_err   <= 1'b0;
      for (int r = 0; r < NUM_RAYS; r++) cnt[r] <= '0;
    end else begin
      if (dec_ready) nxt_valid <= 1'b0;
      if (dec_fire) begin
        if (!any_flag) begin
          flag_err <= 1'b1;
        end else begin
          nxt_valid                        <= 1'b1;
          nxt_ray_id                       <= dec_ray_id;
          {nxt_node, nxt_t_min, nxt_t_max} <= dec_out;
          nxt_done                         <= 1'b0;
        end
        if (push) begin
          if (full) ovf_err <= 1'b1;
          else      cnt[dec_ray_id] <= push_cnt + 1'b1;
        end
      end else if (pop_fire) begin
        nxt_valid  <= 1'b1;
        nxt_ray_id <= pop_ray_id;
        if (pop_cnt != '0) begin
          {nxt_node, nxt_t_min, nxt_t_max} <= pop_ent;
          nxt_done                         <= 1'b0;
          cnt[pop_ray_id]                  <= pop_cnt - 1'b1;
        end else begin
          nxt_node  <= '0;
          nxt_t_min <= '0;
          nxt_t_max <= '0;
          nxt_done  <= 1'b1;
        end
      end
    end
  end

  // Stack payload is not reset; cnt alone decides what is live.
  always_ff @(posedge clk) begin
    if (dec_fire & push & ~full & ~rst)
      stk[dec_ray_id][IW'(push_cnt)] <= push_ent;
  end

endmodule
